// File: rtl/au_cnt_mod.sv
// Bounded up-counter (0..LIMIT) built around one AU_inc incrementer, with
// terminal count, rollover pulse and optional sticky overflow (macro AU_CNT_OVF_STICKY_EN).

module AU_inc #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             co
);
  if (ARCH == 1) begin : g_ripple
    logic [WIDTH:0] c;
    assign c[0] = 1'b1;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign y[i]   = a[i] ^ c[i];
      assign c[i+1] = a[i] & c[i];
    end
    assign co = c[WIDTH];
  end else if (ARCH == 2) begin : g_lookahead
    // each bit flips when every lower bit is one; flat AND per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
        assign y[0] = ~a[0];
      end else begin : g_upper
        assign y[i] = a[i] ^ (&a[i-1:0]);
      end
    end
    assign co = &a;
  end else begin : g_behav
    assign {co, y} = {1'b0, a} + (WIDTH+1)'(1);
  end
endmodule

module au_cnt_mod #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);
  localparam longint MAXV = (longint'(1) << WIDTH) - 1;
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);
  localparam bit FULL = (longint'(LIMIT) == MAXV);

  if (WIDTH < 1 || ARCH < 0 || ARCH > 2 || LIMIT < 1 || longint'(LIMIT) > MAXV) begin : g_param_err
    $fatal(1, "au_cnt_mod: illegal parameters WIDTH=%0d ARCH=%0d LIMIT=%0d", WIDTH, ARCH, LIMIT);
  end

  logic [WIDTH-1:0] cnt_q, cnt_d, inc_y;
  logic             wrap_q, wrap_d, inc_co, at_limit, roll;

  AU_inc #(.WIDTH(WIDTH), .ARCH(ARCH)) u_inc (
    .a  (cnt_q),
    .y  (inc_y),
    .co (inc_co)
  );

  assign at_limit = (cnt_q == LIM);
  // full-range counters roll over exactly on the incrementer's own carry
  assign roll = FULL ? inc_co : at_limit;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = (ld_val > LIM) ? LIM : ld_val;
    end else if (en) begin
      if (roll) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = inc_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef AU_CNT_OVF_STICKY_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wrap_d) begin
      ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign tc   = at_limit;
endmodule

// File: tb/tb_au_cnt_mod.sv
// Directed bench for au_cnt_mod: four instances covering every ARCH, small and
// full-range limits, and the one-bit corner case.

module tb_au_cnt_mod;
`ifdef AU_CNT_OVF_STICKY_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic clk;
  int   n_chk = 0;
  int   n_err = 0;

  logic r9, c9, l9, e9, tc9, w9, o9;
  logic [7:0] v9, cnt9;
  logic r255, c255, l255, e255, tc255, w255, o255;
  logic [7:0] v255, cnt255;
  logic r15, c15, l15, e15, tc15, w15, o15;
  logic [3:0] v15, cnt15;
  logic r1, c1, l1, e1, tc1, w1, o1;
  logic [0:0] v1, cnt1;

  au_cnt_mod #(.WIDTH(8), .ARCH(0), .LIMIT(9)) u9 (
    .clk(clk), .rst(r9), .clr(c9), .ld(l9), .ld_val(v9), .en(e9),
    .cnt(cnt9), .tc(tc9), .wrap(w9), .ovf(o9));
  au_cnt_mod #(.WIDTH(8), .ARCH(1), .LIMIT(255)) u255 (
    .clk(clk), .rst(r255), .clr(c255), .ld(l255), .ld_val(v255), .en(e255),
    .cnt(cnt255), .tc(tc255), .wrap(w255), .ovf(o255));
  au_cnt_mod #(.WIDTH(4), .ARCH(2), .LIMIT(15)) u15 (
    .clk(clk), .rst(r15), .clr(c15), .ld(l15), .ld_val(v15), .en(e15),
    .cnt(cnt15), .tc(tc15), .wrap(w15), .ovf(o15));
  au_cnt_mod #(.WIDTH(1), .ARCH(1), .LIMIT(1)) u1 (
    .clk(clk), .rst(r1), .clr(c1), .ld(l1), .ld_val(v1), .en(e1),
    .cnt(cnt1), .tc(tc1), .wrap(w1), .ovf(o1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    {r9, c9, l9, e9}         = '0; v9   = '0;
    {r255, c255, l255, e255} = '0; v255 = '0;
    {r15, c15, l15, e15}     = '0; v15  = '0;
    {r1, c1, l1, e1}         = '0; v1   = '0;
  endtask

  // one clock edge, then sample 1 ns later and drop all controls
  task automatic tick();
    @(posedge clk);
    #1;
    idle_all();
  endtask

  initial begin
    idle_all();
    @(negedge clk);
    r9 = 1; r255 = 1; r15 = 1; r1 = 1;
    e9 = 1; l255 = 1; v255 = 8'd77; c15 = 1; e1 = 1;
    tick();
    check_val("rst9_cnt", cnt9, 0);   check_val("rst9_tc", tc9, 0);
    check_val("rst9_wrap", w9, 0);    check_val("rst9_ovf", o9, 0);
    check_val("rst255_cnt", cnt255, 0); check_val("rst255_tc", tc255, 0);
    check_val("rst15_cnt", cnt15, 0); check_val("rst1_cnt", cnt1, 0);
    check_val("rst1_tc", tc1, 0);     check_val("rst1_wrap", w1, 0);

    // LIMIT=9 sweep: 1..9 then back to 0
    for (int i = 1; i <= 10; i++) begin
      e9 = 1;
      tick();
      check_val($sformatf("sweep9_cnt_%0d", i), cnt9, (i == 10) ? 0 : i);
      check_val($sformatf("sweep9_tc_%0d", i), tc9, (i == 9) ? 1 : 0);
      check_val($sformatf("sweep9_wrap_%0d", i), w9, (i == 10) ? 1 : 0);
    end
    check_val("sweep9_ovf", o9, OVF_EXP);

    l9 = 1; v9 = 8'd200;
    tick();
    check_val("clamp9_cnt", cnt9, 9); check_val("clamp9_tc", tc9, 1);
    check_val("clamp9_wrap", w9, 0);

    l9 = 1; v9 = 8'd3; e9 = 1;
    tick();
    check_val("ldroll9_cnt", cnt9, 3); check_val("ldroll9_wrap", w9, 0);

    l9 = 1; v9 = 8'd5;
    tick();
    check_val("ld9_cnt", cnt9, 5);

    c9 = 1; l9 = 1; v9 = 8'd7;
    tick();
    check_val("clrld9_cnt", cnt9, 0); check_val("clrld9_wrap", w9, 0);
    check_val("clrld9_ovf", o9, OVF_EXP);

    e9 = 1;
    tick();
    check_val("en9_cnt", cnt9, 1);
    tick();
    check_val("hold9_cnt", cnt9, 1); check_val("hold9_wrap", w9, 0);

    l9 = 1; v9 = 8'd9;
    tick();
    check_val("pre_rst9_tc", tc9, 1);
    r9 = 1; e9 = 1;
    tick();
    check_val("rsten9_cnt", cnt9, 0); check_val("rsten9_wrap", w9, 0);
    check_val("rsten9_ovf", o9, 0);
    e9 = 1;
    tick();
    check_val("resume9_cnt", cnt9, 1);

    // full-range rollover on the ripple incrementer
    l255 = 1; v255 = 8'd254;
    tick();
    check_val("f255_ld", cnt255, 254); check_val("f255_ld_tc", tc255, 0);
    e255 = 1; tick();
    check_val("f255_c1", cnt255, 255); check_val("f255_tc1", tc255, 1);
    check_val("f255_w1", w255, 0);
    e255 = 1; tick();
    check_val("f255_c2", cnt255, 0); check_val("f255_w2", w255, 1);
    check_val("f255_tc2", tc255, 0); check_val("f255_ovf", o255, OVF_EXP);
    e255 = 1; tick();
    check_val("f255_c3", cnt255, 1); check_val("f255_w3", w255, 0);
    l255 = 1; v255 = 8'd127; tick();
    e255 = 1; tick();
    check_val("f255_carry7", cnt255, 128);
    l255 = 1; v255 = 8'd15; tick();
    e255 = 1; tick();
    check_val("f255_carry3", cnt255, 16);

    // 4-bit lookahead full sweep
    for (int i = 1; i <= 16; i++) begin
      e15 = 1;
      tick();
      check_val($sformatf("sweep15_cnt_%0d", i), cnt15, i % 16);
      check_val($sformatf("sweep15_tc_%0d", i), tc15, (i == 15) ? 1 : 0);
      check_val($sformatf("sweep15_wrap_%0d", i), w15, (i == 16) ? 1 : 0);
    end

    // single-bit counter toggles and wraps every second cycle
    for (int i = 1; i <= 4; i++) begin
      e1 = 1;
      tick();
      check_val($sformatf("w1_cnt_%0d", i), cnt1, i % 2);
      check_val($sformatf("w1_tc_%0d", i), tc1, i % 2);
      check_val($sformatf("w1_wrap_%0d", i), w1, (i % 2 == 0) ? 1 : 0);
    end
    check_val("w1_ovf", o1, OVF_EXP);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/au_cnt_mod.md
AU_CNT_MOD -- requirements
Module: au_cnt_mod

Interface
REQ-001 SHALL: Parameter WIDTH, default 8, counter word length (>= 1).
REQ-002 SHALL: Parameter ARCH, default 0, incrementer architecture (0 to 2), forwarded unchanged to the internal AU_inc instance.
REQ-003 SHALL: Parameter LIMIT, default 255, terminal count value (1 to 2^WIDTH-1).
REQ-004 SHALL: Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL: Port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL: Port clr, input, 1, synchronous clear of the count to 0.
REQ-007 SHALL: Port ld, input, 1, load strobe.
REQ-008 SHALL: Port ld_val, input, WIDTH, load value.
REQ-009 SHALL: Port en, input, 1, count enable.
REQ-010 SHALL: Port cnt, output, WIDTH, registered count value.
REQ-011 SHALL: Port tc, output, 1, terminal count: high while cnt == LIMIT.
REQ-012 SHALL: Port wrap, output, 1, registered one-cycle pulse marking a LIMIT-to-0 rollover.
REQ-013 SHALL: Port ovf, output, 1, sticky rollover flag (see Configuration).

Function
REQ-014 SHALL: Compute the next-count value from cnt with one AU_inc instance (WIDTH, ARCH); no other adder is used on the count path.
REQ-015 SHALL: Apply per-cycle priority rst > clr > ld > en > hold.
REQ-016 SHALL: On clr, set cnt = 0 and wrap = 0 in the next cycle; ovf is unaffected.
REQ-017 SHALL: On ld with ld_val <= LIMIT, set cnt = ld_val in the next cycle; with ld_val > LIMIT, set cnt = LIMIT (clamp). wrap = 0.
REQ-018 SHALL: On en with cnt < LIMIT, set cnt = cnt + 1 in the next cycle; wrap = 0.
REQ-019 SHALL: On en with cnt == LIMIT, set cnt = 0 and wrap = 1 in the next cycle (exactly one cycle).
REQ-020 SHALL: Hold cnt and drive wrap = 0 when no control input is active.
REQ-021 SHALL: Decode tc combinationally from the cnt register only; it is independent of en.
REQ-022 SHALL: Give ld priority over en when both are asserted in the same cycle as a rollover, so no wrap is produced.
REQ-023 SHALL: Produce a wrap on every rollover when LIMIT = 2^WIDTH-1, matching the AU_inc natural overflow; cnt never exceeds LIMIT.
REQ-024 SHALL: Keep latency at one cycle from control input to the cnt/wrap update; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL: rst asserted at a clock edge sets cnt = 0, wrap = 0 and ovf = 0, overriding clr, ld and en.
REQ-026 SHALL: rst asserted mid-count discards the in-progress value; counting resumes from 0 on the first enabled cycle after rst deasserts.
REQ-027 SHALL: tc = 1 after reset only if LIMIT == 0, which is illegal; otherwise tc = 0.

Configuration
REQ-028 SHALL: When macro AU_CNT_OVF_STICKY_EN is defined, ovf is set on any cycle in which wrap is set, and held until rst.
REQ-029 SHALL: When AU_CNT_OVF_STICKY_EN is not defined, ovf is tied to 0 and no ovf register is built.
REQ-030 SHALL: Check parameters at simulation start; WIDTH < 1, ARCH outside 0..2, or LIMIT outside 1..2^WIDTH-1 prints an error and calls $finish.

Verification
REQ-031 SHALL: Cover WIDTH=8, LIMIT=9, rst, then en=1 for 10 cycles -> cnt 1..9, then 0; tc=1 only when cnt=9; wrap=1 only in the cycle cnt returns to 0.
REQ-032 SHALL: Cover WIDTH=8, LIMIT=255, ld ld_val=254, then en for 2 cycles -> cnt 254, 255, 0; wrap pulse is one cycle.
REQ-033 SHALL: Cover LIMIT=9, ld ld_val=200 -> cnt=9, tc=1; in the same cycle as a rollover, ld=1 ld_val=3 with en=1 -> cnt=3, wrap=0.
REQ-034 SHALL: Cover cnt=5, clr=1 and ld=1 asserted together -> cnt=0; with the macro defined and ovf=1 beforehand, ovf stays 1.
REQ-035 SHALL: Cover a macro-defined build: force a rollover (ovf goes 1), then rst=1 with en=1 -> cnt=0, wrap=0, ovf=0 next cycle.
REQ-036 SHALL: Cover WIDTH=1, LIMIT=1 with en held high -> cnt toggles 0,1,0,1; wrap pulses every second cycle.
